// File: rtl/spi_fpu_sequencer.sv
// spi_fpu_sequencer: parses SPI frames into FPU commands {op, A, B} and streams the result back.
// Ports: clock/reset (sync, active-high); spi_active_i, rx_valid_i, rx_data_i from spi_rx;
//   tx_valid_o/tx_data_o/tx_ready_i byte handshake to spi_rx;
//   fpu_valid_o/fpu_ready_i, fpu_op_o, fpu_a_o, fpu_b_o command to the FPU;
//   fpu_result_valid_i, fpu_result_i, fpu_flags_i result from the FPU;
//   busy_o (not idle), error_o (sticky bad opcode, cleared at frame start).
module spi_fpu_sequencer #(
  parameter int DATA_BYTES = 4,
  parameter int NUM_OPS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    spi_active_i,
  input  logic                    rx_valid_i,
  input  logic [7:0]              rx_data_i,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    fpu_valid_o,
  input  logic                    fpu_ready_i,
  output logic [7:0]              fpu_op_o,
  output logic [8*DATA_BYTES-1:0] fpu_a_o,
  output logic [8*DATA_BYTES-1:0] fpu_b_o,
  input  logic                    fpu_result_valid_i,
  input  logic [8*DATA_BYTES-1:0] fpu_result_i,
  input  logic [4:0]              fpu_flags_i,
  output logic                    busy_o,
  output logic                    error_o
);
  localparam int W = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTES);
  localparam logic [8:0] NOPS = 9'(NUM_OPS);
  typedef enum logic [2:0] {IDLE, CMD, OPA, OPB, ISSUE, WAIT, SEND, DRAIN} state_t;
  state_t state_q;
  logic act_q, abort_q, tx_valid_q, fpu_valid_q, error_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] tx_data_q, op_q;
  logic [W-1:0] a_q, b_q, res_q;
  logic [4:0] flags_q;
  logic rise, drop;
  assign rise = spi_active_i & ~act_q;
  assign drop = ~spi_active_i & act_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o = tx_data_q;
  assign fpu_valid_o = fpu_valid_q;
  assign fpu_op_o = op_q;
  assign fpu_a_o = a_q;
  assign fpu_b_o = b_q;
  assign busy_o = state_q != IDLE;
  assign error_o = error_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      act_q <= 1'b0;
      abort_q <= 1'b0;
      tx_valid_q <= 1'b0;
      fpu_valid_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q <= '0;
      tx_data_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      act_q <= spi_active_i;
      case (state_q)
        IDLE: if (rise) begin
          state_q <= CMD;
          error_q <= 1'b0;
        end
        CMD: if (drop) state_q <= IDLE;
        else if (rx_valid_i) begin
          if ({1'b0, rx_data_i} < NOPS) begin
            op_q <= rx_data_i;
            cnt_q <= '0;
            state_q <= OPA;
          end else begin
            error_q <= 1'b1;
            state_q <= DRAIN;
          end
        end
        OPA: if (drop) state_q <= IDLE;
        else if (rx_valid_i) begin
          a_q <= (a_q << 8) | W'(rx_data_i);
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= OPB;
        end
        OPB: if (drop) state_q <= IDLE;
        else if (rx_valid_i) begin
          b_q <= (b_q << 8) | W'(rx_data_i);
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= ISSUE;
            fpu_valid_q <= 1'b1;
          end
        end
        // A dropped frame cannot withdraw an offered command; remember it and finish the exchange.
        ISSUE: begin
          if (drop) abort_q <= 1'b1;
          if (fpu_ready_i) begin
            fpu_valid_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (drop) abort_q <= 1'b1;
          if (fpu_result_valid_i) begin
            if (abort_q | drop) begin
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              tx_valid_q <= 1'b1;
              tx_data_q <= fpu_result_i[W-1 -: 8];
              res_q <= fpu_result_i << 8;
              flags_q <= fpu_flags_i;
              cnt_q <= '0;
              state_q <= SEND;
            end
          end
        end
        // res_q holds the bytes still to send, MSB aligned; the status byte follows the last one.
        SEND: if (drop) begin
          tx_valid_q <= 1'b0;
          state_q <= IDLE;
        end else if (tx_ready_i) begin
          if (cnt_q == FULL) begin
            tx_valid_q <= 1'b0;
            cnt_q <= '0;
            state_q <= CMD;
          end else begin
            tx_data_q <= cnt_q == LAST ? {3'b0, flags_q} : res_q[W-1 -: 8];
            res_q <= res_q << 8;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: if (drop) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_fpu_sequencer.sv
// tb_spi_fpu_sequencer: randomized self-checking bench against a frame-level reference model.
module tb_spi_fpu_sequencer;
  logic clock = 0, reset = 1;
  logic spi_active_i = 0, rx_valid_i = 0, tx_ready_i = 0, fpu_ready_i = 0, fpu_result_valid_i = 0;
  logic [7:0] rx_data_i = 0;
  logic [31:0] fpu_result_i = 0;
  logic [4:0] fpu_flags_i = 0;
  logic tx_valid_o, fpu_valid_o, busy_o, error_o;
  logic [7:0] tx_data_o, fpu_op_o;
  logic [31:0] fpu_a_o, fpu_b_o;
  int n_chk = 0, n_pass = 0, fv_hi = 0;
  logic [7:0] last_op = 0;
  spi_fpu_sequencer #(.DATA_BYTES(4), .NUM_OPS(8)) dut (
    .clock(clock), .reset(reset), .spi_active_i(spi_active_i), .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o),
    .fpu_b_o(fpu_b_o), .fpu_result_valid_i(fpu_result_valid_i), .fpu_result_i(fpu_result_i),
    .fpu_flags_i(fpu_flags_i), .busy_o(busy_o), .error_o(error_o)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (fpu_valid_o) fv_hi++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid_i = 1;
    rx_data_i = b;
    tick();
    rx_valid_i = 0;
    repeat (gap) tick();
  endtask
  task automatic start_frame();
    spi_active_i = 1;
    tick();
    chk("start_busy", busy_o, 1);
    chk("err_clr", error_o, 0);
  endtask
  task automatic end_frame();
    spi_active_i = 0;
    tick();
    chk("end_idle", busy_o, 0);
  endtask
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    send_byte(op, $urandom_range(0, 2));
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], $urandom_range(0, 2));
    for (int i = 0; i < 3; i++) send_byte(b[31-8*i -: 8], $urandom_range(0, 2));
    chk("fv_early", fpu_valid_o, 0);
    send_byte(b[7:0], 0);
    last_op = op;
    chk("fv_lat", fpu_valid_o, 1);
    chk("op", fpu_op_o, op);
    chk("a", fpu_a_o, a);
    chk("b", fpu_b_o, b);
  endtask
  task automatic hs(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int rdly);
    logic ok = 1;
    for (int i = 0; i < rdly; i++) begin
      fpu_ready_i = 0;
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i = 8'($urandom);
      tick();
      ok = ok && fpu_valid_o === 1 && fpu_op_o === op && fpu_a_o === a && fpu_b_o === b;
    end
    rx_valid_i = 0;
    fpu_ready_i = 1;
    tick();
    fpu_ready_i = 0;
    chk("issue_hold", ok, 1);
    chk("hs_once", fpu_valid_o, 0);
  endtask
  task automatic pulse(input logic [31:0] r, input logic [4:0] fl);
    fpu_result_valid_i = 1;
    fpu_result_i = r;
    fpu_flags_i = fl;
    tick();
    fpu_result_valid_i = 0;
  endtask
  task automatic collect(input logic [31:0] r, input logic [4:0] fl, input int stall_at);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] prev;
    logic pend;
    logic hold = 1;
    int st = 0, t = 0;
    for (int k = 0; k < 4; k++) exp.push_back(8'((r >> (8 * (3 - k))) & 32'hFF));
    exp.push_back({3'b0, fl});
    chk("tx_lat", tx_valid_o, 1);
    while (got.size() < 5 && t < 300) begin
      t++;
      if (stall_at == got.size() && st < 10) begin
        tx_ready_i = 0;
        st++;
      end else tx_ready_i = $urandom_range(0, 3) != 0;
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i = 8'($urandom);
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      pend = tx_valid_o && !tx_ready_i;
      prev = tx_data_o;
      tick();
      if (pend) hold = hold && tx_valid_o && tx_data_o == prev;
    end
    tx_ready_i = 0;
    rx_valid_i = 0;
    chk("tx_cnt", 64'(got.size()), 5);
    for (int k = 0; k < got.size() && k < 5; k++) chk("tx_byte", got[k], exp[k]);
    chk("tx_hold", hold, 1);
    chk("tx_done", tx_valid_o, 0);
    chk("back_cmd", busy_o, 1);
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [4:0] fl, input int rdly, input int stall_at);
    logic ok = 1;
    send_cmd(op, a, b);
    hs(op, a, b, rdly);
    repeat ($urandom_range(0, 3)) begin
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i = 8'($urandom);
      tick();
      ok = ok && !tx_valid_o;
    end
    rx_valid_i = 0;
    chk("wait_quiet", ok, 1);
    pulse(r, fl);
    collect(r, fl, stall_at);
  endtask
  task automatic bad_cmd(input logic [7:0] op);
    int f0;
    f0 = fv_hi;
    send_byte(op, 0);
    chk("err_set", error_o, 1);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    chk("err_nofv", 64'(fv_hi), 64'(f0));
    chk("drain_busy", busy_o, 1);
  endtask
  initial begin
    logic ok;
    repeat (3) tick();
    chk("rst_ab", {fpu_a_o, fpu_b_o}, 0);
    chk("rst_ctl", {tx_valid_o, tx_data_o, fpu_valid_o, fpu_op_o, busy_o, error_o}, 0);
    reset = 0;
    tick();
    chk("rst_idle", busy_o, 0);
    start_frame();
    run_cmd(8'h01, 32'h3F800000, 32'h40000000, 32'h40400000, 5'h0, 0, -1);
    end_frame();
    start_frame();
    bad_cmd(8'h0F);
    end_frame();
    chk("err_sticky", error_o, 1);
    start_frame();
    run_cmd(8'h07, $urandom, $urandom, $urandom, 5'($urandom), 1, -1);
    end_frame();
    start_frame();
    rx_valid_i = 1;
    rx_data_i = 8'h05;
    spi_active_i = 0;
    tick();
    rx_valid_i = 0;
    chk("drop_win", busy_o, 0);
    chk("drop_byte", fpu_op_o, last_op);
    start_frame();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 0);
    spi_active_i = 0;
    tick();
    chk("drop_idle", busy_o, 0);
    chk("drop_nofv", fpu_valid_o, 0);
    start_frame();
    run_cmd(8'h02, $urandom, $urandom, $urandom, 5'($urandom), 0, -1);
    run_cmd(8'h03, $urandom, $urandom, $urandom, 5'($urandom), 6, -1);
    run_cmd(8'h04, $urandom, $urandom, $urandom, 5'($urandom), 0, 2);
    end_frame();
    start_frame();
    send_cmd(8'h05, 32'h12345678, 32'h9ABCDEF0);
    hs(8'h05, 32'h12345678, 32'h9ABCDEF0, 0);
    spi_active_i = 0;
    tick();
    spi_active_i = 1;
    ok = 1;
    repeat (4) begin
      tick();
      ok = ok && !tx_valid_o && busy_o;
    end
    chk("abort_wait", ok, 1);
    pulse(32'hDEADBEEF, 5'h1F);
    chk("abort_idle", busy_o, 0);
    chk("abort_notx", tx_valid_o, 0);
    repeat (2) tick();
    chk("rise_ignored", busy_o, 0);
    spi_active_i = 0;
    tick();
    start_frame();
    send_cmd(8'h06, 32'h0BADF00D, 32'h00C0FFEE);
    spi_active_i = 0;
    tick();
    chk("abort_issue_fv", fpu_valid_o, 1);
    hs(8'h06, 32'h0BADF00D, 32'h00C0FFEE, 2);
    pulse(32'h11111111, 5'h3);
    chk("abort_issue_idle", busy_o, 0);
    chk("abort_issue_notx", tx_valid_o, 0);
    start_frame();
    send_cmd(8'h01, 32'hCAFEBABE, 32'h01020304);
    hs(8'h01, 32'hCAFEBABE, 32'h01020304, 0);
    pulse(32'h55AA55AA, 5'h4);
    chk("send_tx", tx_valid_o, 1);
    reset = 1;
    tick();
    chk("rstsend_ab", {fpu_a_o, fpu_b_o}, 0);
    chk("rstsend_ctl", {tx_valid_o, tx_data_o, fpu_valid_o, fpu_op_o, busy_o, error_o}, 0);
    reset = 0;
    spi_active_i = 0;
    last_op = 0;
    tick();
    for (int f = 0; f < 25; f++) begin
      start_frame();
      for (int c = $urandom_range(1, 3); c > 0; c--) begin
        if ($urandom_range(0, 5) == 0) begin
          bad_cmd(8'($urandom_range(8, 255)));
          break;
        end
        run_cmd(8'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 1) ? -1 : $urandom_range(0, 4));
      end
      end_frame();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
